key_schedule_ctrl: RTL
======================

Name: key_schedule_ctrl

Overview:
- Sequences the GenSubKey round-key datapath through all 10 AES-128 expansion rounds, starting from one cipher key.
- Supplies each round's Rcon and previous round key to GenSubKey, then waits for its valid_out handshake.
- Stores the 11 round keys (index 0..10) in an internal register file with a registered read port for the cipher rounds.
- Includes a response watchdog so a stalled datapath is flagged rather than hanging the system.

Parameters:
- KEY_LEN, 128, round key width in bits.
- WORD_LEN, 32, Rcon word width in bits.
- NUM_ROUNDS, 10, number of expansion rounds; keys stored = NUM_ROUNDS+1.
- TIMEOUT, 64, maximum cycles to wait for gsk_valid_out after issue before flagging an error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to expand key_in; accepted only when busy=0.
- key_in  in  KEY_LEN  cipher key, sampled in the cycle start is accepted.
- gsk_rcon  out  WORD_LEN  Rcon driven to GenSubKey.Rcon.
- gsk_data_in  out  KEY_LEN  previous round key driven to GenSubKey.data_in.
- gsk_valid_in  out  1  GenSubKey.valid_in; one-cycle pulse per round.
- gsk_data_out  in  KEY_LEN  GenSubKey.data_out.
- gsk_valid_out  in  1  GenSubKey.valid_out.
- rd_addr  in  4  round key index to read, 0..10.
- rd_key  out  KEY_LEN  registered read data.
- busy  out  1  expansion in progress.
- keys_ready  out  1  all 11 keys valid.
- done  out  1  one-cycle pulse when round 10 key is stored.
- err  out  1  sticky watchdog timeout flag.

Behaviour:
- Reset values (async): all outputs 0, state IDLE, round counter 0, key file cleared, watchdog 0.
- State IDLE:
  - start=1 stores key_in at index 0, sets round=1, clears keys_ready and err, sets busy=1, and moves to ISSUE.
- State ISSUE (1 cycle):
  - gsk_valid_in=1.
  - gsk_data_in = key[round-1]; gsk_rcon = RC(round) in byte [31:24], low 24 bits 0.
  - RC(1..10) = 01,02,04,08,10,20,40,80,1b,36.
  - Clears the watchdog and goes to WAIT.
- State WAIT:
  - gsk_valid_in=0; gsk_data_in and gsk_rcon held stable.
  - gsk_valid_out=1 stores gsk_data_out at index round.
    - If round < NUM_ROUNDS: round+1, go to ISSUE.
    - Otherwise: go to DONE.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 with no valid_out: err=1, busy=0, keys_ready=0, go to IDLE.
- State DONE (1 cycle): done=1, keys_ready=1, busy=0, go to IDLE.
- Latency:
  - start to the first gsk_valid_in is 1 cycle.
  - Each round costs 1 issue cycle plus the GenSubKey response latency.
  - Total = sum of round latencies + 10 issue cycles + 1.
- Ignored inputs:
  - start while busy=1 is ignored; no restart and no key overwrite.
  - gsk_valid_out in IDLE, ISSUE or DONE is ignored; keys are unchanged.
- Read port:
  - rd_key updates on the clock edge after rd_addr is presented (1-cycle latency).
  - rd_addr > 10 returns 0.
  - Reads are legal at any time; a read during expansion returns whatever is stored.
- keys_ready stays 1 after DONE until the next accepted start or reset.
- Reset asserted mid-expansion immediately returns to IDLE with all state cleared. No gsk_valid_in is produced after reset releases until a new start.
- Simultaneous gsk_valid_out and watchdog expiry: valid_out wins, the key is stored, and err is not set.

Test Plan:
- FIPS-197 key: start with key_in=2b7e151628aed2a6abf7158809cf4f3c, real GenSubKey attached.
  - Expect exactly 10 gsk_valid_in pulses with gsk_rcon 01000000 through 36000000.
  - Expect done pulse, keys_ready=1.
  - rd_addr=1 -> a0fafe1788542cb123a339392a6c7605; rd_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; rd_addr=0 -> key_in.
- Variable-latency stub (random delay 1..20 cycles per round):
  - Keys stored in order and gsk_data_in stable throughout each WAIT.
  - No second gsk_valid_in is issued before the pending gsk_valid_out.
- Start during busy:
  - A second start with key 000102...0f at round 4 is ignored.
  - Final keys still match the 2b7e... expansion.
- Watchdog: stub never returns valid_out in round 3.
  - err=1 exactly TIMEOUT cycles after the issue; busy=0, keys_ready=0.
  - A following start clears err and completes normally.
- Reset mid-operation: assert reset during round 6 WAIT.
  - All outputs go to 0 asynchronously and rd_key reads 0 afterwards.
  - A late gsk_valid_out after reset is ignored.
- Out-of-range read: rd_addr=11..15 -> rd_key=0 one cycle later.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// key_schedule_ctrl
//
// Drives an external GenSubKey round-key datapath through the AES-128 key
// expansion. The controller issues one round at a time and waits for each
// response before issuing the next. It keeps all NUM_ROUNDS+1 round keys in
// a local register file, and a registered read port serves them to the
// cipher rounds.
//
// A watchdog bounds the wait for each GenSubKey response. When it expires the
// expansion is abandoned and the sticky err flag is raised.
//
// State table
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; keys and flags hold their last values
//   S_ISSUE | one-cycle gsk_valid_in pulse for the current round
//   S_WAIT  | waiting for gsk_valid_out, watchdog running
//   S_DONE  | one-cycle done pulse after the last round key is stored
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   start          expansion request, honoured only while busy is low
//   key_in         cipher key, captured with an accepted start
//   gsk_rcon       Rcon word to GenSubKey (RC byte in the top byte)
//   gsk_data_in    previous round key to GenSubKey
//   gsk_valid_in   one-cycle issue pulse per round
//   gsk_data_out   next round key from GenSubKey
//   gsk_valid_out  GenSubKey response strobe
//   rd_addr        round key index to read (0..NUM_ROUNDS)
//   rd_key         registered read data, 0 for out-of-range indices
//   busy           expansion in progress
//   keys_ready     all round keys valid
//   done           one-cycle pulse when the final round key is stored
//   err            sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module key_schedule_ctrl #(
    parameter int KEY_LEN    = 128,
    parameter int WORD_LEN   = 32,
    parameter int NUM_ROUNDS = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [KEY_LEN-1:0]  key_in,
    output logic [WORD_LEN-1:0] gsk_rcon,
    output logic [KEY_LEN-1:0]  gsk_data_in,
    output logic                gsk_valid_in,
    input  logic [KEY_LEN-1:0]  gsk_data_out,
    input  logic                gsk_valid_out,
    input  logic [3:0]          rd_addr,
    output logic [KEY_LEN-1:0]  rd_key,
    output logic                busy,
    output logic                keys_ready,
    output logic                done,
    output logic                err
);

    localparam int NUM_KEYS = NUM_ROUNDS + 1;
    localparam int WD_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    // The watchdog counts down from TIMEOUT-2 so that terminal count is hit on
    // the edge where an up-counter started at 0 would reach TIMEOUT-1. That
    // puts err on the bus exactly TIMEOUT cycles after the issue cycle.
    localparam logic [WD_W-1:0] WD_LOAD   = WD_W'(TIMEOUT - 2);
    localparam logic [3:0]      LAST_RND  = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [3:0]           round_q;
    logic [WD_W-1:0]      wd_q;
    logic                 keys_ready_q;
    logic                 err_q;
    logic [KEY_LEN-1:0]   key_file [NUM_KEYS];

    logic                 start_acc;
    logic                 resp;
    logic                 last_round;
    logic                 wd_expire;
    logic [3:0]           round_prev;
    logic [WORD_LEN-1:0]  rcon_word;

    // AES round constants for rounds 1..10.
    function automatic logic [7:0] rc_byte(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // busy is low in DONE as well, so a start there is taken just like in IDLE.
    assign start_acc  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign resp       = (state_q == S_WAIT) && gsk_valid_out;
    assign last_round = (round_q == LAST_RND);
    // A response in the expiry cycle wins, so expiry requires no valid_out.
    assign wd_expire  = (state_q == S_WAIT) && !gsk_valid_out && (wd_q == '0);
    assign round_prev = round_q - 4'd1;
    assign rcon_word  = {rc_byte(round_q), {(WORD_LEN-8){1'b0}}};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_acc) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (resp) begin
                    state_d = last_round ? S_DONE : S_ISSUE;
                end else if (wd_expire) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = start_acc ? S_ISSUE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        gsk_valid_in = 1'b0;
        gsk_data_in  = '0;
        gsk_rcon     = '0;
        busy         = 1'b0;
        done         = 1'b0;
        keys_ready   = keys_ready_q;
        err          = err_q;
        case (state_q)
            S_ISSUE: begin
                gsk_valid_in = 1'b1;
                busy         = 1'b1;
                gsk_data_in  = key_file[round_prev];
                gsk_rcon     = rcon_word;
            end
            S_WAIT: begin
                // round_q and key_file[round_q-1] do not change until the
                // response arrives, so both buses hold through the wait.
                busy         = 1'b1;
                gsk_data_in  = key_file[round_prev];
                gsk_rcon     = rcon_word;
            end
            S_DONE: begin
                done         = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Round counter, watchdog, status flags, key file and read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round_q      <= '0;
            wd_q         <= '0;
            keys_ready_q <= 1'b0;
            err_q        <= 1'b0;
            rd_key       <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_file[i] <= '0;
            end
        end else begin
            if (start_acc) begin
                key_file[0]  <= key_in;
                round_q      <= 4'd1;
                keys_ready_q <= 1'b0;
                err_q        <= 1'b0;
            end

            if (state_q == S_ISSUE) begin
                wd_q <= WD_LOAD;
            end

            if (resp) begin
                key_file[round_q] <= gsk_data_out;
                if (last_round) begin
                    keys_ready_q <= 1'b1;
                end else begin
                    round_q <= round_q + 4'd1;
                end
            end else if (wd_expire) begin
                err_q        <= 1'b1;
                keys_ready_q <= 1'b0;
            end else if (state_q == S_WAIT) begin
                wd_q <= wd_q - 1'b1;
            end

            rd_key <= (rd_addr <= LAST_RND) ? key_file[rd_addr] : '0;
        end
    end

endmodule
